seq_alu_param: RTL and testbench

Parametrised, multi-cycle successor to the 16-bit ALU. Operand width is set by a parameter. It uses a start/busy/done handshake in place of a free-running registered result. Multiply is sequential shift-add and divide is sequential restoring, so neither needs combinational wide arithmetic. It produces zero, carry and error flags. It sits between the register file/control unit and the cache datapath.

---
 rtl/seq_alu_param.sv | 221 ++++++++++++++++++++++
 tb/tb_seq_alu_param.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_param.sv
// Multi-cycle signed ALU with a start/busy/done handshake. Multiply is a
// shift-add over WIDTH steps and divide is restoring over WIDTH steps.
module seq_alu_param #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           opcode,
  input  logic [WIDTH-1:0]     operand_a,
  input  logic [WIDTH-1:0]     operand_b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 zero,
  output logic                 carry,
  output logic                 err,
  output logic [1:0]           dbg_state
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_LLS = 4'b0111;
  localparam logic [3:0] OP_LRS = 4'b1000;
  localparam logic [3:0] OP_INC = 4'b1001;
  localparam logic [3:0] OP_DEC = 4'b1010;

  localparam logic [WIDTH-1:0] W_AMT  = WIDTH'(WIDTH);
  localparam logic [WIDTH:0]   ONE_W1 = (WIDTH+1)'(1);
  localparam logic [CNT_W-1:0] CNT_LD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake: start is taken only on a rising edge where busy=0. busy stays
  // high from that edge through the done cycle; done is a one-cycle pulse
  // during which result/zero/carry/err are valid. They hold until the next done.

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mag_q, mag_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;
  logic                 rneg_q, rneg_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 carry_q, carry_d;
  logic                 err_q, err_d;

  function automatic logic [2*WIDTH-1:0] sext(input logic [WIDTH-1:0] v);
    return {{WIDTH{v[WIDTH-1]}}, v};
  endfunction

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum_w, dif_w, inc_w, dec_w;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_err;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next, step_next;
  logic [2*WIDTH-1:0] prod_fin;
  logic [WIDTH-1:0]   quot_fin, rem_fin;
  logic               load_res;
  logic [2*WIDTH-1:0] res_new;
  logic               carry_new, err_new;

  always_comb begin
    mag_a = operand_a[WIDTH-1] ? -operand_a : operand_a;
    mag_b = operand_b[WIDTH-1] ? -operand_b : operand_b;
    sum_w = {1'b0, operand_a} + {1'b0, operand_b};
    dif_w = {1'b0, operand_a} - {1'b0, operand_b};
    inc_w = {1'b0, operand_a} + ONE_W1;
    dec_w = {1'b0, operand_a} - ONE_W1;

    alu_res = '0;
    alu_c   = 1'b0;
    alu_err = 1'b0;
    case (opcode)
      OP_ADD: begin alu_res = sum_w[WIDTH-1:0]; alu_c = sum_w[WIDTH]; end
      OP_SUB: begin alu_res = dif_w[WIDTH-1:0]; alu_c = dif_w[WIDTH]; end
      OP_INC: begin alu_res = inc_w[WIDTH-1:0]; alu_c = inc_w[WIDTH]; end
      OP_DEC: begin alu_res = dec_w[WIDTH-1:0]; alu_c = dec_w[WIDTH]; end
      OP_AND: alu_res = operand_a & operand_b;
      OP_OR:  alu_res = operand_a | operand_b;
      OP_XOR: alu_res = operand_a ^ operand_b;
      OP_LLS: alu_res = (operand_b >= W_AMT) ? '0 : (operand_a << operand_b);
      OP_LRS: alu_res = (operand_b >= W_AMT) ? '0 : (operand_a >> operand_b);
      default: alu_err = 1'b1;
    endcase
  end

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient}
  // for DIV; mag holds the multiplicand or the divisor magnitude.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mag_q};
    if (div_trial[WIDTH]) begin
      div_next = {acc_q[2*WIDTH-2:0], 1'b0};
    end else begin
      div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
    step_next = is_div_q ? div_next : mul_next;
    prod_fin  = neg_q ? -step_next : step_next;
    quot_fin  = neg_q ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0];
    rem_fin   = rneg_q ? -step_next[2*WIDTH-1:WIDTH] : step_next[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mag_d     = mag_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    result_d  = result_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    err_d     = err_q;
    load_res  = 1'b0;
    res_new   = '0;
    carry_new = 1'b0;
    err_new   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          neg_d  = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
          rneg_d = operand_a[WIDTH-1];
          if (opcode == OP_MUL) begin
            is_div_d = 1'b0;
            acc_d    = {{WIDTH{1'b0}}, mag_b};
            mag_d    = mag_a;
            cnt_d    = CNT_LD;
            state_d  = S_ITER;
          end else if (opcode == OP_DIV && operand_b != '0) begin
            is_div_d = 1'b1;
            acc_d    = {{WIDTH{1'b0}}, mag_a};
            mag_d    = mag_b;
            cnt_d    = CNT_LD;
            state_d  = S_ITER;
          end else begin
            // Divide by zero lands here too: alu_err is set for OP_DIV.
            load_res  = 1'b1;
            res_new   = alu_err ? '0 : sext(alu_res);
            carry_new = alu_c;
            err_new   = alu_err;
            state_d   = S_DONE;
          end
        end
      end
      S_ITER: begin
        acc_d = step_next;
        cnt_d = cnt_q - CNT_1;
        if (cnt_q == CNT_1) begin
          load_res = 1'b1;
          res_new  = is_div_q ? {rem_fin, quot_fin} : prod_fin;
          state_d  = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (load_res) begin
      result_d = res_new;
      zero_d   = (res_new == '0);
      carry_d  = carry_new;
      err_d    = err_new;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mag_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mag_q    <= mag_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_alu_param.sv
// Directed bench for seq_alu_param at WIDTH=16: a vector table plus
// hand-written sequences for ignored starts and a reset abort mid-multiply.
module tb_seq_alu_param;
  localparam int W = 16;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_LLS = 4'b0111;
  localparam logic [3:0] OP_LRS = 4'b1000;
  localparam logic [3:0] OP_INC = 4'b1001;
  localparam logic [3:0] OP_DEC = 4'b1010;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [3:0]     opcode;
  logic [W-1:0]   operand_a, operand_b;
  logic           busy, done;
  logic [2*W-1:0] result;
  logic           zero, carry, err;
  logic [1:0]     dbg_state;

  seq_alu_param #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .result(result),
    .zero(zero), .carry(carry), .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  typedef struct {
    string          name;
    logic [3:0]     op;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] res;
    logic           z, c, e;
    int             lat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string name, input logic [3:0] op,
                              input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [2*W-1:0] res, input logic z,
                              input logic c, input logic e, input int lat);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.res = res;
    v.z = z; v.c = c; v.e = e; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // poke: cycle after accept at which a stray ADD start is driven (0 = none).
  // start_at_done: drive start during the done cycle and confirm it is dropped.
  task automatic run_op(input vec_t v, input int poke, input bit start_at_done);
    int lat;
    int busy_cnt;
    logic [2*W-1:0] exp_res;
    @(negedge clk);
    start = 1'b1; opcode = v.op; operand_a = v.a; operand_b = v.b;
    exp_q.push_back(v.res);
    @(posedge clk);
    lat = 0;
    busy_cnt = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
      end else if (poke != 0 && k == poke) begin
        start = 1'b1; opcode = OP_ADD;
        operand_a = W'($urandom_range(1, 1000)); operand_b = W'($urandom_range(1, 1000));
      end else if (poke != 0 && k == poke + 1) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    exp_res = exp_q.pop_front();
    check({v.name, " latency"}, lat, v.lat);
    if (lat != 0) begin
      check({v.name, " result"}, result, exp_res);
      check({v.name, " zero"}, zero, v.z);
      check({v.name, " carry"}, carry, v.c);
      check({v.name, " err"}, err, v.e);
      check({v.name, " busy cycles"}, busy_cnt, lat);
      if (start_at_done) begin
        start = 1'b1; opcode = OP_ADD; operand_a = 16'd1; operand_b = 16'd1;
        @(negedge clk);
        start = 1'b0;
        check({v.name, " start at done busy"}, busy, 1'b0);
        check({v.name, " start at done pulse"}, done, 1'b0);
        check({v.name, " result held"}, result, exp_res);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back(mk("add_ovf",  OP_ADD, 16'h7FFF, 16'h0001, 32'hFFFF8000, 0, 0, 0, 1));
    tbl.push_back(mk("add_wrap", OP_ADD, 16'hFFFF, 16'h0001, 32'h00000000, 1, 1, 0, 1));
    tbl.push_back(mk("add_pos",  OP_ADD, 16'h1234, 16'h4321, 32'h00005555, 0, 0, 0, 1));
    tbl.push_back(mk("sub_neg",  OP_SUB, 16'h0003, 16'h0005, 32'hFFFFFFFE, 0, 1, 0, 1));
    tbl.push_back(mk("dec_zero", OP_DEC, 16'h0000, 16'h0000, 32'hFFFFFFFF, 0, 1, 0, 1));
    tbl.push_back(mk("inc_wrap", OP_INC, 16'hFFFF, 16'h0000, 32'h00000000, 1, 1, 0, 1));
    tbl.push_back(mk("and",      OP_AND, 16'hF0F0, 16'h0FF0, 32'h000000F0, 0, 0, 0, 1));
    tbl.push_back(mk("or",       OP_OR,  16'h8000, 16'h0001, 32'hFFFF8001, 0, 0, 0, 1));
    tbl.push_back(mk("xor",      OP_XOR, 16'hAAAA, 16'hFFFF, 32'h00005555, 0, 0, 0, 1));
    tbl.push_back(mk("lls",      OP_LLS, 16'd10,   16'd2,    32'd40,       0, 0, 0, 1));
    tbl.push_back(mk("lrs",      OP_LRS, 16'h008A, 16'd4,    32'd8,        0, 0, 0, 1));
    tbl.push_back(mk("lls_wide", OP_LLS, 16'd1,    16'd16,   32'd0,        1, 0, 0, 1));
    tbl.push_back(mk("lrs_15",   OP_LRS, 16'h8000, 16'd15,   32'd1,        0, 0, 0, 1));
    tbl.push_back(mk("illegal",  4'b1100, 16'h1234, 16'h5678, 32'd0,       1, 0, 1, 1));
    tbl.push_back(mk("mul_mix",  OP_MUL, 16'hFED4, 16'h00C8, 32'hFFFF15A0, 0, 0, 0, 17));
    tbl.push_back(mk("mul_neg",  OP_MUL, 16'h0007, 16'hFFF8, 32'hFFFFFFC8, 0, 0, 0, 17));
    tbl.push_back(mk("mul_min",  OP_MUL, 16'h8000, 16'h8000, 32'h40000000, 0, 0, 0, 17));
    tbl.push_back(mk("mul_zero", OP_MUL, 16'h0000, 16'h1234, 32'h00000000, 1, 0, 0, 17));
    tbl.push_back(mk("div_neg",  OP_DIV, 16'hFFE7, 16'h0004, 32'hFFFFFFFA, 0, 0, 0, 17));
    tbl.push_back(mk("div_by0",  OP_DIV, 16'd25,   16'h0000, 32'h00000000, 1, 0, 1, 1));
    tbl.push_back(mk("div_min",  OP_DIV, 16'h8000, 16'hFFFF, 32'h00008000, 0, 0, 0, 17));
    tbl.push_back(mk("div_nb",   OP_DIV, 16'd100,  16'hFFF9, 32'h0002FFF2, 0, 0, 0, 17));
    tbl.push_back(mk("div_nn",   OP_DIV, 16'hFFF9, 16'hFFFE, 32'hFFFF0003, 0, 0, 0, 17));

    reset = 1'b0; start = 1'b0; opcode = '0; operand_a = '0; operand_b = '0;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset result", result, 32'd0);
    check("reset zero", zero, 1'b0);
    check("reset carry", carry, 1'b0);
    check("reset err", err, 1'b0);
    check("reset state", dbg_state, 2'd0);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run_op(tbl[i], 0, 1'b0);

    // Stray start mid-multiply, then a start that coincides with done.
    run_op(mk("mul_poke", OP_MUL, 16'hFED4, 16'h00C8, 32'hFFFF15A0, 0, 0, 0, 17), 5, 1'b1);
    run_op(mk("add_done", OP_ADD, 16'd7, 16'd9, 32'd16, 0, 0, 0, 1), 0, 1'b1);

    // Reset abort in cycle 8 of a multiply.
    run_op(mk("add_pre", OP_ADD, 16'd1, 16'd1, 32'd2, 0, 0, 0, 1), 0, 1'b0);
    @(negedge clk);
    start = 1'b1; opcode = OP_MUL; operand_a = 16'd300; operand_b = 16'd200;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    check("abort busy before", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort result", result, 32'd0);
    check("abort state", dbg_state, 2'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("abort no stale done", done, 1'b0);
    end
    run_op(mk("add_after", OP_ADD, 16'd2, 16'd3, 32'd5, 0, 0, 0, 1), 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
